// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle MIPS datapath: fetch, decode, execute, memory, write-back.
// Moore outputs except the FETCH IR/PC loads, which follow the memory ready handshake.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_op,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state;
    state_t next_state;
    state_t out_state;
    logic   illegal_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            illegal_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == ILLEGAL) begin
                illegal_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:     next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:      next_state = EXECUTE;
                    OP_LW, OP_SW:  next_state = MEM_ADDR;
                    OP_BEQ:        next_state = BRANCH;
                    OP_J:          next_state = JUMP;
                    OP_ADDI:       next_state = ADDI_EXEC;
                    default:       next_state = ILLEGAL;
                endcase
            end
            MEM_ADDR:  next_state = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = MemReady ? MEM_WB : MEM_READ;
            MEM_WRITE: next_state = MemReady ? FETCH : MEM_WRITE;
            EXECUTE:   next_state = R_WB;
            ADDI_EXEC: next_state = ADDI_WB;
            MEM_WB,
            R_WB,
            ADDI_WB,
            BRANCH,
            JUMP,
            ILLEGAL:   next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    // While reset is held the datapath sees FETCH controls, so an interrupted
    // memory write or register write cannot leak out during the reset cycle.
    assign out_state = reset ? FETCH : state;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALU_op      = 2'b00;
        PCSource    = 2'b00;
        case (out_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALU_op  = 2'b10;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_op      = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign IllegalOp = illegal_flag;
    assign State     = state;

endmodule
